cmv_pipe_streamer: RTL and testbench

Host-side consumer of the CMV300 capture FIFO read port. On a host frame trigger it handshakes a frame start into the sensor capture block, then presents the captured frame to an Opal Kelly block-throttled pipe-out one block at a time, gating FIFO reads so the host only ever pulls complete blocks. All logic runs in the host/pipe clock, which is also the FIFO read clock.

---
 rtl/cmv_stream_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/cmv_pipe_streamer.sv | 136 +++++++++++++
 tb/tb_cmv_pipe_streamer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmv_stream_pkg.sv
// Shared state encoding, default frame sizing and CMV300 geometry for the pipe streamer.
package cmv_stream_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_REQ      = 3'd2,
    S_ARM      = 3'd3,
    S_BLOCK    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam int SENSOR_WIDTH    = 648;
  localparam int SENSOR_HEIGHT   = 488;
  localparam int FRAME_PAD_BYTES = 192;

  localparam int DEF_BLOCK_WORDS = 256;
  // 648*488 + 192 = 316416 bytes = 79104 words, exactly 309 blocks of 256.
  localparam int DEF_FRAME_WORDS = (SENSOR_WIDTH * SENSOR_HEIGHT + FRAME_PAD_BYTES) / 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchroniser, async active-low reset to 0; output lags input by 2-3 clocks.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cmv_pipe_streamer.sv
// Frame-triggered FIFO-to-pipe streamer: block-gated reads, data latency 1, host throttled by o_pipe_ready.
// CMV_STREAM_TEST_PATTERN_EN replaces FIFO data with the in-frame word index (FIFO still drains).
module cmv_pipe_streamer
  import cmv_stream_pkg::*;
#(
  parameter int BLOCK_WORDS      = DEF_BLOCK_WORDS,
  parameter int FRAME_WORDS      = DEF_FRAME_WORDS,
  parameter int BLOCKS_PER_FRAME = FRAME_WORDS / BLOCK_WORDS
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_trig,
  input  logic        i_cmos_ready,
  output logic        o_cmos_start,
  input  logic        i_fifo_prog_full,
  input  logic [31:0] i_fifo_data,
  output logic        o_fifo_read_en,
  input  logic        i_pipe_read,
  output logic        o_pipe_ready,
  output logic [31:0] o_pipe_data,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [15:0] o_blocks_sent,
  output logic        o_err
);

  localparam int                WCNT_W     = $clog2(BLOCK_WORDS) + 1;
  localparam logic [WCNT_W-1:0] WCNT_FULL  = WCNT_W'(BLOCK_WORDS);
  localparam logic [WCNT_W-1:0] WCNT_LAST  = WCNT_W'(BLOCK_WORDS - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE   = WCNT_W'(1);
  localparam logic [15:0]       BLK_FULL   = 16'(BLOCKS_PER_FRAME);
  localparam logic [15:0]       BLK_PENULT = 16'(BLOCKS_PER_FRAME - 1);

  state_t            state;
  logic [WCNT_W-1:0] wcnt;
  logic              rdy_s;
  logic              rd_ok;

  sync_2ff u_rdy_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (i_cmos_ready),
    .q     (rdy_s)
  );

  // Only reads inside an unfinished block reach the FIFO; anything else is a host protocol error.
  assign rd_ok          = (state == S_BLOCK) && (wcnt != WCNT_FULL);
  assign o_fifo_read_en = i_pipe_read && rd_ok;
  assign o_busy         = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      wcnt          <= '0;
      o_cmos_start  <= 1'b0;
      o_pipe_ready  <= 1'b0;
      o_frame_done  <= 1'b0;
      o_blocks_sent <= '0;
      o_err         <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (i_pipe_read && !rd_ok) o_err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (i_frame_trig) begin
            o_blocks_sent <= '0;
            o_err         <= 1'b0;
            state         <= S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (rdy_s) begin
            o_cmos_start <= 1'b1;
            state        <= S_REQ;
          end
        end
        // Capture block drops ready once it has taken the request.
        S_REQ: begin
          if (!rdy_s) begin
            o_cmos_start <= 1'b0;
            state        <= S_ARM;
          end
        end
        S_ARM: begin
          if (i_fifo_prog_full) begin
            o_pipe_ready <= 1'b1;
            wcnt         <= '0;
            state        <= S_BLOCK;
          end
        end
        S_BLOCK: begin
          if (o_fifo_read_en) begin
            wcnt         <= wcnt + WCNT_ONE;
            o_pipe_ready <= 1'b0;
            if (wcnt == WCNT_LAST) begin
              if (o_blocks_sent != BLK_FULL) o_blocks_sent <= o_blocks_sent + 16'd1;
              if (o_blocks_sent >= BLK_PENULT) begin
                o_frame_done <= 1'b1;
                state        <= S_DONE;
              end else begin
                state <= S_ARM;
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CMV_STREAM_TEST_PATTERN_EN
  logic [31:0] word_idx;
  logic [31:0] pattern;
  logic        unused_fifo_data;

  assign unused_fifo_data = ^i_fifo_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_idx <= '0;
      pattern  <= '0;
    end else if (state == S_IDLE && i_frame_trig) begin
      word_idx <= '0;
    end else if (o_fifo_read_en) begin
      pattern  <= word_idx;
      word_idx <= word_idx + 32'd1;
    end
  end

  assign o_pipe_data = pattern;
`else
  assign o_pipe_data = i_fifo_data;
`endif

endmodule

// File: tb/tb_cmv_pipe_streamer.sv
// Randomized bench: sensor/FIFO model plus host pipe reader, checked against a frame-level reference.
module tb_cmv_pipe_streamer;

  localparam int BW  = 16;
  localparam int BPF = 12;
  localparam int FW  = BW * BPF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_trig = 1'b0;
  logic        cmos_ready;
  logic        cmos_start;
  logic        prog_full;
  logic [31:0] fifo_dout = 32'd0;
  logic        fifo_rd;
  logic        pipe_read = 1'b0;
  logic        pipe_ready;
  logic [31:0] pipe_data;
  logic        busy;
  logic        frame_done;
  logic [15:0] blocks_sent;
  logic        err;

  bit          auto_mode = 1'b0;
  logic        man_rdy = 1'b0;
  logic        sens_rdy = 1'b1;
  int          fifo_cnt = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] gen_arr[FW];
  logic [31:0] w;
  int          prod_left = 0;
  int          prod_idx = 0;
  int          pops = 0;
  int          underflow = 0;
  int          done_cnt = 0;
  int          host_idx = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign cmos_ready = auto_mode ? sens_rdy : man_rdy;
  assign prog_full  = (fifo_cnt >= BW);

  cmv_pipe_streamer #(
    .BLOCK_WORDS      (BW),
    .FRAME_WORDS      (FW),
    .BLOCKS_PER_FRAME (BPF)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_frame_trig     (frame_trig),
    .i_cmos_ready     (cmos_ready),
    .o_cmos_start     (cmos_start),
    .i_fifo_prog_full (prog_full),
    .i_fifo_data      (fifo_dout),
    .o_fifo_read_en   (fifo_rd),
    .i_pipe_read      (pipe_read),
    .o_pipe_ready     (pipe_ready),
    .o_pipe_data      (pipe_data),
    .o_busy           (busy),
    .o_frame_done     (frame_done),
    .o_blocks_sent    (blocks_sent),
    .o_err            (err)
  );

  // Capture block + FIFO: accepts a start while ready, flushes, then streams a random frame.
  always @(posedge clk) begin
    if (fifo_rd) begin
      pops++;
      if (fifo_q.size() == 0) underflow++;
      else fifo_dout <= fifo_q.pop_front();
    end
    if (auto_mode) begin
      if (sens_rdy && cmos_start) begin
        sens_rdy <= 1'b0;
        fifo_q.delete();
        prod_left = FW;
        prod_idx  = 0;
      end else if (prod_left > 0) begin
        if ($urandom_range(3) != 0) begin
          w = $urandom;
          fifo_q.push_back(w);
          gen_arr[prod_idx] = w;
          prod_idx++;
          prod_left--;
        end
      end else if (!sens_rdy && !cmos_start) begin
        sens_rdy <= 1'b1;
      end
    end
    fifo_cnt <= fifo_q.size();
  end

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  function automatic logic [31:0] exp_word(input int idx);
`ifdef CMV_STREAM_TEST_PATTERN_EN
    return 32'(idx);
`else
    return gen_arr[idx];
`endif
  endfunction

  task automatic host_reads(input int n, input bit extra, input bit gaps);
    int issued = 0;
    int pend = -1;
    bit first = 1'b1;
    int p0 = pops;
    while (issued < n || pend >= 0) begin
      @(negedge clk);
      if (pend >= 0) begin
        n_checks++;
        if (pipe_data !== exp_word(pend)) begin
          n_fail++;
          $display("FAIL pipe_data word %0d got=%h exp=%h", pend, pipe_data, exp_word(pend));
        end
        if (first) begin
          n_checks++;
          if (pipe_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_drop word %0d got=%b exp=0", pend, pipe_ready);
          end
          first = 1'b0;
        end
        pend = -1;
      end
      if (issued < n && (!gaps || $urandom_range(3) != 0)) begin
        pipe_read = 1'b1;
        pend = host_idx;
        host_idx++;
        issued++;
      end else begin
        pipe_read = 1'b0;
      end
    end
    if (extra) begin
      pipe_read = 1'b1;
      #1;
      n_checks++;
      if (fifo_rd !== 1'b0) begin
        n_fail++;
        $display("FAIL overread_forwarded got=%b exp=0", fifo_rd);
      end
      @(negedge clk);
      pipe_read = 1'b0;
      n_checks++;
      if (err !== 1'b1) begin
        n_fail++;
        $display("FAIL overread_err got=%b exp=1", err);
      end
    end
    pipe_read = 1'b0;
    n_checks++;
    if (pops - p0 != n) begin
      n_fail++;
      $display("FAIL block_fifo_reads got=%0d exp=%0d", pops - p0, n);
    end
  endtask

  task automatic do_frame(input int over_blk, input int abort_blk, input int abort_word, input bit mid_trig);
    int t;
    int done0 = done_cnt;
    int pops0 = pops;
    host_idx = 0;
    @(negedge clk);
    frame_trig = 1'b1;
    @(negedge clk);
    frame_trig = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || err !== 1'b0 || blocks_sent !== 16'd0) begin
      n_fail++;
      $display("FAIL trig_start busy/err/blocks got=%b/%b/%0d exp=1/0/0", busy, err, blocks_sent);
    end
    for (int b = 0; b < BPF; b++) begin
      t = 0;
      while (pipe_ready !== 1'b1 && t < 5000) begin
        @(negedge clk);
        t++;
      end
      n_checks++;
      if (t >= 5000) begin
        n_fail++;
        $display("FAIL ready_timeout block %0d got=%b exp=1", b, pipe_ready);
        return;
      end
      n_checks++;
      if (blocks_sent !== 16'(b)) begin
        n_fail++;
        $display("FAIL blocks_sent_progress got=%0d exp=%0d", blocks_sent, b);
      end
      if (mid_trig && b == 2) begin
        frame_trig = 1'b1;
        @(negedge clk);
        frame_trig = 1'b0;
      end
      if (b == abort_blk) begin
        host_reads(abort_word, 1'b0, 1'b0);
        pipe_read = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cmos_start, fifo_rd, pipe_ready, busy, frame_done, err} !== 6'b0 || blocks_sent !== 16'd0) begin
          n_fail++;
          $display("FAIL async_reset_outputs got=%b/%0d exp=000000/0",
                   {cmos_start, fifo_rd, pipe_ready, busy, frame_done, err}, blocks_sent);
        end
`ifdef CMV_STREAM_TEST_PATTERN_EN
        n_checks++;
        if (pipe_data !== 32'd0) begin
          n_fail++;
          $display("FAIL async_reset_pattern got=%h exp=0", pipe_data);
        end
`endif
        pipe_read = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      host_reads(BW, b == over_blk, b != over_blk);
    end
    t = 0;
    while (busy === 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (done_cnt - done0 != 1) begin
      n_fail++;
      $display("FAIL frame_done_pulses got=%0d exp=1", done_cnt - done0);
    end
    n_checks++;
    if (blocks_sent !== 16'(BPF) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_end blocks/busy got=%0d/%b exp=%0d/0", blocks_sent, busy, BPF);
    end
    n_checks++;
    if (pops - pops0 != FW || underflow != 0) begin
      n_fail++;
      $display("FAIL frame_words reads/underflow got=%0d/%0d exp=%0d/0", pops - pops0, underflow, FW);
    end
    n_checks++;
    if (err !== (over_blk >= 0)) begin
      n_fail++;
      $display("FAIL frame_err got=%b exp=%b", err, over_blk >= 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmos_start, fifo_rd, pipe_ready, busy, frame_done, err} !== 6'b0 ||
        blocks_sent !== 16'd0 || pipe_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b/%0d/%h exp=000000/0/0",
               {cmos_start, fifo_rd, pipe_ready, busy, frame_done, err}, blocks_sent, pipe_data);
    end
  endtask

  task automatic test_handshake();
    int lat = 0;
    int drop = 0;
    bit hold_ok = 1'b1;
    man_rdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    frame_trig = 1'b1;
    do begin
      @(negedge clk);
      frame_trig = 1'b0;
      lat++;
    end while (cmos_start !== 1'b1 && lat < 10);
    n_checks++;
    if (lat != 2) begin
      n_fail++;
      $display("FAIL start_latency got=%0d exp=2", lat);
    end
    repeat (5) begin
      @(negedge clk);
      if (cmos_start !== 1'b1 || busy !== 1'b1) hold_ok = 1'b0;
    end
    n_checks++;
    if (!hold_ok) begin
      n_fail++;
      $display("FAIL start_hold got=%b exp=1", cmos_start);
    end
    man_rdy = 1'b0;
    do begin
      @(negedge clk);
      drop++;
    end while (cmos_start !== 1'b0 && drop < 10);
    n_checks++;
    if (drop < 2 || drop > 3) begin
      n_fail++;
      $display("FAIL start_drop got=%0d cycles exp=2..3", drop);
    end
  endtask

  task automatic test_arm_stall();
    int bad = 0;
    int notbusy = 0;
    repeat (1000) begin
      @(negedge clk);
      if (pipe_ready !== 1'b0 || fifo_rd !== 1'b0) bad++;
      if (busy !== 1'b1) notbusy++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL arm_stall ready/read cycles got=%0d exp=0", bad);
    end
    n_checks++;
    if (notbusy != 0) begin
      n_fail++;
      $display("FAIL arm_stall_busy idle cycles got=%0d exp=0", notbusy);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    auto_mode = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic test_full_frame();
    do_frame(-1, -1, 0, 1'b0);
  endtask

  task automatic test_overread();
    do_frame(3, -1, 0, 1'b0);
  endtask

  task automatic test_async_reset();
    do_frame(-1, 5, 7, 1'b0);
    do_frame(-1, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_frame(-1, -1, 0, 1'b1);
    do_frame(-1, -1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_arm_stall();
    test_full_frame();
    test_overread();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
